// File: rtl/hilo_mul_ctrl.sv
// hilo_mul_ctrl: drives a signed 32x32 multiplier for MULT, low word first and
// then high word, and owns the architectural HI/LO registers.
//
// state   | meaning
// IDLE    | no operation; serves MTHI/MTLO writes and accepts start
// REQ_LO  | low-word request strobe on the multiplier interface
// WAIT_LO | waiting for the low word; watchdog counting
// REQ_HI  | high-word request strobe on the multiplier interface
// WAIT_HI | waiting for the high word; watchdog counting
// FIN     | HI and LO both updated; done pulse
module hilo_mul_ctrl #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  input  logic        i_hi_we,
  input  logic        i_lo_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_mul_valid,
  output logic [31:0] o_mul_a,
  output logic [31:0] o_mul_b,
  output logic        o_mul_lo_hi,
  input  logic [31:0] i_mul_result,
  input  logic        i_mul_valid_out
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQ_LO  = 3'd1;
  localparam logic [2:0] WAIT_LO = 3'd2;
  localparam logic [2:0] REQ_HI  = 3'd3;
  localparam logic [2:0] WAIT_HI = 3'd4;
  localparam logic [2:0] FIN     = 3'd5;

  // Counter only has to reach TIMEOUT_CYC-1.
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic          r_err;
  logic          r_mul_valid;
  logic [31:0]   r_mul_a;
  logic [31:0]   r_mul_b;
  logic          r_mul_lo_hi;
  logic          w_timeout;

  // Watchdog limit reached this cycle; a response in the same cycle still wins.
  assign w_timeout = (r_cnt == LIMIT);

  // Sequencer, HI/LO registers, request strobes and watchdog.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_err       <= 1'b0;
      r_mul_valid <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_lo_hi <= 1'b0;
    end else begin
      r_mul_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_mul_a     <= i_op_a;
            r_mul_b     <= i_op_b;
            r_err       <= 1'b0;
            r_mul_valid <= 1'b1;
            r_mul_lo_hi <= 1'b1;
            r_state     <= REQ_LO;
          end else begin
            if (i_hi_we) r_hi <= i_wdata;
            if (i_lo_we) r_lo <= i_wdata;
          end
        end
        REQ_LO: begin
          r_cnt   <= '0;
          r_state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (i_mul_valid_out) begin
            r_lo        <= i_mul_result;
            r_mul_valid <= 1'b1;
            r_mul_lo_hi <= 1'b0;
            r_state     <= REQ_HI;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        REQ_HI: begin
          r_cnt   <= '0;
          r_state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (i_mul_valid_out) begin
            r_hi    <= i_mul_result;
            r_state <= FIN;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        FIN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Status and register outputs.
  always_comb begin
    o_busy      = (r_state != IDLE);
    o_done      = (r_state == FIN);
    o_hi        = r_hi;
    o_lo        = r_lo;
    o_err       = r_err;
    o_mul_valid = r_mul_valid;
    o_mul_a     = r_mul_a;
    o_mul_b     = r_mul_b;
    o_mul_lo_hi = r_mul_lo_hi;
  end

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Bench for hilo_mul_ctrl: a 2-cycle multiplier model answers requests, and a
// reference of HI/LO is kept from plain 64-bit signed arithmetic.
module tb_hilo_mul_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_op_a = '0;
  logic [31:0] i_op_b = '0;
  logic        i_hi_we = 1'b0;
  logic        i_lo_we = 1'b0;
  logic [31:0] i_wdata = '0;
  logic [31:0] o_hi, o_lo, o_mul_a, o_mul_b;
  logic        o_busy, o_done, o_err, o_mul_valid, o_mul_lo_hi;
  logic [31:0] i_mul_result = '0;
  logic        i_mul_valid_out = 1'b0;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  // multiplier model control: 0 silent, 1 normal, 2 answers low-word only
  int   mdl_mode = 1;
  bit   inj = 1'b0;
  bit   cd = 1'b0;
  logic [31:0] pend = '0;
  logic [63:0] mdl_p;

  hilo_mul_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_op_a(i_op_a), .i_op_b(i_op_b),
    .i_hi_we(i_hi_we), .i_lo_we(i_lo_we), .i_wdata(i_wdata),
    .o_hi(o_hi), .o_lo(o_lo), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_mul_valid(o_mul_valid), .o_mul_a(o_mul_a), .o_mul_b(o_mul_b),
    .o_mul_lo_hi(o_mul_lo_hi), .i_mul_result(i_mul_result),
    .i_mul_valid_out(i_mul_valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
  endfunction

  assign mdl_p = prod(o_mul_a, o_mul_b);

  // Multiplier model: answers two cycles after a request is seen.
  always @(posedge clk) begin
    i_mul_valid_out <= 1'b0;
    if (cd) begin
      i_mul_valid_out <= 1'b1;
      i_mul_result    <= pend;
      cd              <= 1'b0;
    end
    if (o_mul_valid && (mdl_mode == 1 || (mdl_mode == 2 && o_mul_lo_hi))) begin
      pend <= o_mul_lo_hi ? mdl_p[31:0] : mdl_p[63:32];
      cd   <= 1'b1;
    end
    if (inj) begin
      i_mul_valid_out <= 1'b1;
      i_mul_result    <= 32'hDEADBEEF;
    end
  end

  task automatic test_reset;
    @(negedge clk); i_rst = 1'b1;
    @(negedge clk); @(negedge clk); i_rst = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (5) @(negedge clk);
    nvec++; if (o_hi !== 32'h0) begin nerr++; $display("FAIL reset_hi got %h want 0", o_hi); end
    nvec++; if (o_lo !== 32'h0) begin nerr++; $display("FAIL reset_lo got %h want 0", o_lo); end
    nvec++; if (o_busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", o_busy); end
    nvec++; if (o_done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b want 0", o_done); end
    nvec++; if (o_mul_valid !== 1'b0) begin nerr++; $display("FAIL reset_mul_valid got %b want 0", o_mul_valid); end
    nvec++; if (o_err !== 1'b0) begin nerr++; $display("FAIL reset_err got %b want 0", o_err); end
  endtask

  // One MULT: start in cycle 0, requests expected in 1 and 4, done in 7.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                          input bit busy_wr, input bit start_lo_we);
    logic [63:0] p;
    int cyc, dcyc, ndone;
    int vq[$];
    bit busy_ok;
    p = prod(a, b);
    @(negedge clk);
    i_op_a = a; i_op_b = b; i_start = 1'b1;
    if (start_lo_we) begin i_lo_we = 1'b1; i_wdata = 32'hA5A5A5A5; end
    cyc = 0; dcyc = -1; ndone = 0; busy_ok = 1'b1;
    while (cyc < 40 && dcyc < 0) begin
      @(negedge clk); cyc++;
      if (cyc == 1) begin
        i_start = 1'b0; i_lo_we = 1'b0;
        i_op_a = $urandom; i_op_b = $urandom;
        nvec++; if (o_err !== 1'b0) begin nerr++; $display("FAIL err_clear_on_start got %b want 0", o_err); end
      end
      if (cyc == 2 && start_lo_we) begin
        nvec++; if (o_lo !== m_lo) begin nerr++; $display("FAIL start_lo_we_dropped lo got %h want %h", o_lo, m_lo); end
      end
      if (busy_wr && cyc == 2) begin i_hi_we = 1'b1; i_wdata = 32'h12345678; end
      if (busy_wr && cyc == 3) i_hi_we = 1'b0;
      if (cyc < 7 && o_busy !== 1'b1) busy_ok = 1'b0;
      if (o_mul_valid) begin
        vq.push_back(cyc);
        nvec++;
        if (o_mul_lo_hi !== (cyc == 1)) begin
          nerr++; $display("FAIL lo_hi_select cycle %0d got %b want %b", cyc, o_mul_lo_hi, (cyc == 1));
        end
      end
      if (o_done) begin dcyc = cyc; ndone++; end
    end
    nvec++;
    if (vq.size() != 2 || vq[0] != 1 || vq[1] != 4) begin
      nerr++; $display("FAIL req_timing got %0d requests (first %0d) want cycles 1 and 4",
                       vq.size(), (vq.size() > 0) ? vq[0] : -1);
    end
    nvec++; if (dcyc != 7) begin nerr++; $display("FAIL done_cycle got %0d want 7", dcyc); end
    nvec++; if (!busy_ok) begin nerr++; $display("FAIL busy_during_op got low want high"); end
    nvec++; if (o_lo !== p[31:0]) begin nerr++; $display("FAIL product_lo a=%h b=%h got %h want %h", a, b, o_lo, p[31:0]); end
    nvec++; if (o_hi !== p[63:32]) begin nerr++; $display("FAIL product_hi a=%h b=%h got %h want %h", a, b, o_hi, p[63:32]); end
    m_hi = p[63:32]; m_lo = p[31:0];
  endtask

  task automatic test_basic;
    run_mult(32'd7, -32'sd3, 1'b0, 1'b0);
    nvec++; if (o_lo !== 32'hFFFFFFEB) begin nerr++; $display("FAIL basic_lo got %h want FFFFFFEB", o_lo); end
    nvec++; if (o_hi !== 32'hFFFFFFFF) begin nerr++; $display("FAIL basic_hi got %h want FFFFFFFF", o_hi); end
  endtask

  task automatic test_back_to_back;
    run_mult(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0);
    nvec++; if ({o_hi, o_lo} !== 64'h3FFFFFFF_00000001) begin nerr++; $display("FAIL b2b_first got %h%h want 3FFFFFFF00000001", o_hi, o_lo); end
    run_mult(32'h80000000, 32'h80000000, 1'b0, 1'b0);
    nvec++; if ({o_hi, o_lo} !== 64'h40000000_00000000) begin nerr++; $display("FAIL b2b_second got %h%h want 4000000000000000", o_hi, o_lo); end
  endtask

  task automatic test_writes;
    run_mult(32'd1000, 32'd3, 1'b1, 1'b0);
    @(negedge clk); i_hi_we = 1'b1; i_wdata = 32'h12345678;
    @(negedge clk); i_hi_we = 1'b0;
    m_hi = 32'h12345678;
    nvec++; if (o_hi !== m_hi) begin nerr++; $display("FAIL idle_hi_write got %h want %h", o_hi, m_hi); end
    nvec++; if (o_lo !== m_lo) begin nerr++; $display("FAIL idle_hi_write_lo got %h want %h", o_lo, m_lo); end
    @(negedge clk); i_hi_we = 1'b1; i_lo_we = 1'b1; i_wdata = 32'hCAFEF00D;
    @(negedge clk); i_hi_we = 1'b0; i_lo_we = 1'b0;
    m_hi = 32'hCAFEF00D; m_lo = 32'hCAFEF00D;
    nvec++; if (o_hi !== m_hi || o_lo !== m_lo) begin nerr++; $display("FAIL idle_both_write got %h/%h want %h/%h", o_hi, o_lo, m_hi, m_lo); end
    run_mult(32'hFFFF0000, 32'h00012345, 1'b0, 1'b1);
  endtask

  task automatic test_random;
    for (int k = 0; k < 10; k++) run_mult($urandom, $urandom, 1'b0, 1'b0);
  endtask

  // mode 0: no response at all; mode 2: low word answered, high word never.
  task automatic test_timeout(input int mode);
    logic [63:0] p;
    int cyc, ecyc, want;
    bit saw_done;
    p = prod(32'h00000123, 32'hFFFFF000);
    mdl_mode = mode;
    @(negedge clk); i_op_a = 32'h00000123; i_op_b = 32'hFFFFF000; i_start = 1'b1;
    cyc = 0; ecyc = -1; saw_done = 1'b0;
    while (cyc < 40 && ecyc < 0) begin
      @(negedge clk); cyc++;
      if (cyc == 1) i_start = 1'b0;
      if (o_done) saw_done = 1'b1;
      if (o_err === 1'b1) ecyc = cyc;
    end
    want = (mode == 0) ? (2 + TO) : (5 + TO);
    nvec++; if (ecyc != want) begin nerr++; $display("FAIL timeout_cycle mode %0d got %0d want %0d", mode, ecyc, want); end
    nvec++; if (o_busy !== 1'b0) begin nerr++; $display("FAIL timeout_busy got %b want 0", o_busy); end
    nvec++; if (saw_done) begin nerr++; $display("FAIL timeout_done got pulse want none"); end
    if (mode == 2) m_lo = p[31:0];
    nvec++; if (o_hi !== m_hi || o_lo !== m_lo) begin nerr++; $display("FAIL timeout_hilo got %h/%h want %h/%h", o_hi, o_lo, m_hi, m_lo); end
    repeat (3) @(negedge clk);
    nvec++; if (o_err !== 1'b1) begin nerr++; $display("FAIL err_sticky got %b want 1", o_err); end
    mdl_mode = 1;
  endtask

  task automatic test_reset_mid;
    @(negedge clk); i_op_a = 32'd12345; i_op_b = 32'd678; i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    repeat (4) @(negedge clk);
    nvec++; if (o_lo !== 32'd8369910) begin nerr++; $display("FAIL mid_lo_captured got %h want %h", o_lo, 32'd8369910); end
    i_rst = 1'b1;
    @(negedge clk);
    nvec++; if (o_busy !== 1'b0 || o_mul_valid !== 1'b0) begin nerr++; $display("FAIL mid_reset_idle busy %b valid %b want 0 0", o_busy, o_mul_valid); end
    nvec++; if (o_hi !== 32'h0 || o_lo !== 32'h0) begin nerr++; $display("FAIL mid_reset_hilo got %h/%h want 0/0", o_hi, o_lo); end
    i_rst = 1'b0; inj = 1'b1;
    m_hi = '0; m_lo = '0;
    @(negedge clk); inj = 1'b0;
    nvec++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin nerr++; $display("FAIL stray_resp busy %b done %b want 0 0", o_busy, o_done); end
    @(negedge clk);
    nvec++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_lo !== 32'h0 || o_hi !== 32'h0) begin
      nerr++; $display("FAIL stray_after busy %b done %b lo %h hi %h want 0 0 0 0", o_busy, o_done, o_lo, o_hi);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_writes;
    test_random;
    test_timeout(0);
    run_mult(32'hFFFFFFFE, 32'd9, 1'b0, 1'b0);
    test_timeout(2);
    test_reset_mid;
    run_mult(32'd3, 32'd5, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
